// File: rtl/dma_rd_sequencer.sv
// DMA read sequencer: splits a CSR-requested transfer into line-sized AXI4 INCR
// read bursts (one outstanding) and forwards the returned beats as AXI4-Stream.
module dma_rd_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [1:0]            o_dbg_state
);

    localparam int BL_W       = ADDR_WIDTH - 2;
    localparam int LINE_BYTES = MAX_BEATS * (DATA_WIDTH / 8);
    localparam int LINE_SHIFT = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic                  arvalid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic                  err_seen_q;
    logic [BL_W-1:0]       beats_left_q;
    logic [BL_W-1:0]       beats_left_d;
    logic [7:0]            burst_cnt_q;
    logic [7:0]            burst_cnt_d;

    logic in_data;
    logic beat;
    logic exp_last;
    logic burst_end;
    logic beat_err;
    logic start_bad;

    function automatic logic [7:0] burst_len(input logic [BL_W-1:0] beats);
        if (beats >= BL_W'(MAX_BEATS)) return 8'(MAX_BEATS - 1);
        else return 8'(beats - 1'b1);
    endfunction

    // R and stream are tied together in S_DATA so no beat is ever buffered here.
    assign in_data       = (state_q == S_DATA);
    assign m_axi_rready  = in_data & m_axis_tready;
    assign m_axis_tvalid = in_data & m_axi_rvalid;
    assign m_axis_tlast  = in_data & (beats_left_q == BL_W'(1));
    assign m_axis_tdata  = m_axi_rdata;

    assign beat         = in_data & m_axi_rvalid & m_axis_tready;
    assign exp_last     = (burst_cnt_q == 8'd0);
    assign burst_end    = m_axi_rlast | exp_last;
    assign beat_err     = err_seen_q | (m_axi_rresp != 2'b00) | (m_axi_rlast != exp_last);
    assign beats_left_d = beats_left_q - 1'b1;
    assign burst_cnt_d  = burst_cnt_q - 1'b1;
    assign start_bad    = (i_base_addr[LINE_SHIFT-1:0] != '0) || (i_len == '0) || (i_len[1:0] != 2'b00);

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_dbg_state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_seen_q   <= 1'b0;
            beats_left_q <= '0;
            burst_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_seen_q <= 1'b0;
                        if (start_bad) begin
                            error_q <= 1'b1;
                        end else begin
                            beats_left_q <= i_len[ADDR_WIDTH-1:2];
                            araddr_q     <= i_base_addr;
                            arlen_q      <= burst_len(i_len[ADDR_WIDTH-1:2]);
                            arvalid_q    <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q   <= 1'b0;
                        burst_cnt_q <= arlen_q;
                        state_q     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        beats_left_q <= beats_left_d;
                        burst_cnt_q  <= burst_cnt_d;
                        if (beat_err) err_seen_q <= 1'b1;
                        // A burst ends at rlast or at the expected final beat, whichever is first.
                        if (burst_end) begin
                            if (beat_err) begin
                                error_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else if (beats_left_d == '0) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                araddr_q  <= araddr_q + ADDR_WIDTH'(LINE_BYTES);
                                arlen_q   <= burst_len(beats_left_d);
                                arvalid_q <= 1'b1;
                                state_q   <= S_ADDR;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_rd_sequencer.sv
// Bench for dma_rd_sequencer: a table of transfers run against an AXI slave
// model, with AR and stream expectations queued at start and checked on handshake.
module tb_dma_rd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [31:0] i_len;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [1:0]  o_dbg_state;

    dma_rd_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_len         (i_len),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int    checks;
    int    errors;
    string cur_tag;

    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic [31:0] exp_ar_addr_q[$];
    logic [7:0]  exp_ar_len_q[$];
    logic [31:0] bq_addr[$];
    logic [7:0]  bq_len[$];

    // slave behaviour knobs, set per transfer
    int ar_delay;
    int tready_toggle;
    int err_burst;
    int err_beat;
    int early_burst;
    int early_beat;
    int burst_idx;

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        int          ar_delay;
        int          toggle;
        int          busy_starts;
        int          err_burst;
        int          err_beat;
        int          early_burst;
        int          early_beat;
        int          exp_ars;
        int          exp_beats;
        int          exp_done;
    } vec_t;

    function automatic vec_t mk_vec(input logic [31:0] base, input logic [31:0] len,
                                    input int ard, input int tog, input int bst,
                                    input int eb, input int ebt, input int lb, input int lbt,
                                    input int ars, input int beats, input int dn);
        vec_t v;
        v.base = base; v.len = len; v.ar_delay = ard; v.toggle = tog; v.busy_starts = bst;
        v.err_burst = eb; v.err_beat = ebt; v.early_burst = lb; v.early_beat = lbt;
        v.exp_ars = ars; v.exp_beats = beats; v.exp_done = dn;
        return v;
    endfunction

    function automatic logic [31:0] beat_data(input logic [31:0] a);
        return a ^ 32'hC3C3_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=%0h expected=%0h", cur_tag, name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s %s actual=event expected=none", cur_tag, name);
    endtask

    // ---------------- AXI slave + stream sink, all driven at negedge ----------------
    initial begin : bus
        int          ar_wait;
        int          beat;
        bit          active;
        bit          r_hold;
        logic [31:0] b_addr;
        logic [7:0]  b_len;
        logic [31:0] hold_addr;
        logic [7:0]  hold_len;
        ar_wait = 0; beat = 0; active = 0; r_hold = 0;
        b_addr = '0; b_len = '0; hold_addr = '0; hold_len = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ar_wait = 0; active = 0; r_hold = 0;
                bq_addr.delete(); bq_len.delete();
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                m_axi_rresp = 2'b00; m_axis_tready = 1'b1;
                continue;
            end
            m_axis_tready = (tready_toggle != 0) ? ~m_axis_tready : 1'b1;
            m_axi_arready = 1'b0;
            if (m_axi_arvalid) begin
                if (ar_wait == 0) begin
                    hold_addr = m_axi_araddr;
                    hold_len  = m_axi_arlen;
                end else begin
                    check("ar_addr_stable", m_axi_araddr, hold_addr);
                    check("ar_len_stable", {24'd0, m_axi_arlen}, {24'd0, hold_len});
                end
                if (ar_wait >= ar_delay) m_axi_arready = 1'b1;
                else ar_wait++;
            end
            if (!active && bq_addr.size() > 0) begin
                b_addr = bq_addr.pop_front();
                b_len  = bq_len.pop_front();
                beat   = 0;
                active = 1;
            end
            if (active) begin
                if (!r_hold) m_axi_rvalid = ($urandom_range(0, 3) != 0);
                m_axi_rdata = beat_data(b_addr + 32'(4 * beat));
                m_axi_rresp = (burst_idx == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast = (beat == int'(b_len)) || (burst_idx == early_burst && beat == early_beat);
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
            #1;
            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar_addr_q.size() == 0) begin
                    fail_event("ar_unexpected");
                end else begin
                    check("ar_addr", m_axi_araddr, exp_ar_addr_q.pop_front());
                    check("ar_len", {24'd0, m_axi_arlen}, {24'd0, exp_ar_len_q.pop_front()});
                end
                check("ar_size", {29'd0, m_axi_arsize}, 32'd2);
                check("ar_burst", {30'd0, m_axi_arburst}, 32'd1);
                bq_addr.push_back(m_axi_araddr);
                bq_len.push_back(m_axi_arlen);
                ar_wait = 0;
            end
            if (m_axi_rvalid) check("rready_eq_tready", m_axi_rready, m_axis_tready);
            if (m_axi_rvalid && m_axi_rready) begin
                check("tvalid", m_axis_tvalid, 1'b1);
                if (exp_q.size() == 0) begin
                    fail_event("beat_unexpected");
                end else begin
                    check("tdata", m_axis_tdata, exp_q.pop_front());
                    check("tlast", m_axis_tlast, exp_last_q.pop_front());
                end
                r_hold = 0;
                if (m_axi_rlast) begin
                    active = 0;
                    burst_idx++;
                end else begin
                    beat++;
                end
            end else begin
                r_hold = m_axi_rvalid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_expect();
        exp_q.delete(); exp_last_q.delete();
        exp_ar_addr_q.delete(); exp_ar_len_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        i_start = 1'b0;
        clear_expect();
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_error", o_error, 1'b0);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_araddr", m_axi_araddr, 32'd0);
        check("rst_arlen", {24'd0, m_axi_arlen}, 32'd0);
        check("rst_rready", m_axi_rready, 1'b0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_state", {30'd0, o_dbg_state}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic prep_and_start(input vec_t v);
        logic [31:0] a;
        int rem, n, total;
        ar_delay = v.ar_delay; tready_toggle = v.toggle;
        err_burst = v.err_burst; err_beat = v.err_beat;
        early_burst = v.early_burst; early_beat = v.early_beat;
        burst_idx = 0;
        total = int'(v.len >> 2);
        a = v.base;
        rem = total;
        for (int i = 0; i < v.exp_ars; i++) begin
            n = (rem > 16) ? 16 : rem;
            exp_ar_addr_q.push_back(a);
            exp_ar_len_q.push_back(8'(n - 1));
            a = a + 32'd64;
            rem = rem - n;
        end
        for (int k = 0; k < v.exp_beats; k++) begin
            exp_q.push_back(beat_data(v.base + 32'(4 * k)));
            exp_last_q.push_back(k == total - 1);
        end
        @(negedge clk);
        i_base_addr = v.base;
        i_len = v.len;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        #2;
        check("arvalid_t1", m_axi_arvalid, v.exp_ars > 0);
        check("busy_t1", o_busy, v.exp_ars > 0);
        check("error_t1", o_error, v.exp_ars == 0);
        check("done_t1", o_done, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        prep_and_start(v);
        cyc = 0;
        while (o_busy && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (v.busy_starts != 0 && (cyc == 7 || cyc == 40)) begin
                i_base_addr = 32'h0000_0100;
                i_len = 32'd64;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        if (o_busy) begin
            fail_event("timeout_busy");
            do_reset();
        end else begin
            repeat (3) @(negedge clk);
            #2;
            check("done_end", o_done, v.exp_done != 0);
            check("error_end", o_error, v.exp_done == 0);
            check("busy_end", o_busy, 1'b0);
            check("arvalid_end", m_axi_arvalid, 1'b0);
            check("beats_left_over", exp_q.size(), 32'd0);
            check("ars_left_over", exp_ar_addr_q.size(), 32'd0);
        end
        clear_expect();
        tready_toggle = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : test
        vec_t vecs[10];
        vec_t v;
        int   cyc;
        checks = 0; errors = 0; cur_tag = "reset";
        ar_delay = 0; tready_toggle = 0; err_burst = -1; err_beat = -1;
        early_burst = -1; early_beat = -1; burst_idx = 0;
        rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_len = '0;

        //                base          len   ard tog bst ebu ebt lbu lbt ars beats done
        vecs[0] = mk_vec(32'h1000_0000, 256,  0,  0,  0,  -1, -1, -1, -1, 4,  64,  1);
        vecs[1] = mk_vec(32'h2000_0040, 100,  0,  0,  0,  -1, -1, -1, -1, 2,  25,  1);
        vecs[2] = mk_vec(32'h3000_0004, 64,   0,  0,  0,  -1, -1, -1, -1, 0,  0,   0);
        vecs[3] = mk_vec(32'h3000_0000, 0,    0,  0,  0,  -1, -1, -1, -1, 0,  0,   0);
        vecs[4] = mk_vec(32'h3000_0000, 6,    0,  0,  0,  -1, -1, -1, -1, 0,  0,   0);
        vecs[5] = mk_vec(32'h4000_0000, 256,  0,  0,  0,  1,  2,  -1, -1, 2,  32,  0);
        vecs[6] = mk_vec(32'h5000_0000, 128,  5,  1,  1,  -1, -1, -1, -1, 2,  32,  1);
        vecs[7] = mk_vec(32'h6000_0000, 64,   0,  0,  0,  -1, -1, 0,  3,  1,  4,   0);
        vecs[8] = mk_vec(32'h7000_0000, 4,    0,  0,  0,  -1, -1, -1, -1, 1,  1,   1);
        vecs[9] = mk_vec(32'h7000_1000, 68,   2,  0,  0,  -1, -1, -1, -1, 2,  17,  1);

        repeat (2) @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        // reset in the middle of a burst, then a clean single-burst restart
        cur_tag = "midreset";
        v = mk_vec(32'h8000_0000, 256, 0, 0, 0, -1, -1, -1, -1, 4, 64, 1);
        prep_and_start(v);
        cyc = 0;
        while (exp_q.size() > 58 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        #2;
        check("mid_state", {30'd0, o_dbg_state}, 32'd2);
        check("mid_busy", o_busy, 1'b1);
        do_reset();
        cur_tag = "restart";
        run_vec(mk_vec(32'h9000_0000, 64, 0, 0, 0, -1, -1, -1, -1, 1, 16, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
